pwm_seq_ctrl: RTL

Duty-cycle sequencer for the 4-channel PWM timer. It holds a small buffer of per-channel compare-value sets and plays them back one entry per PWM period. Each entry is presented on `crr_o` with a one-cycle load strobe, timed to the PWM period-boundary pulse. It sits between the APB register file, which fills the buffer and starts playback, and the PWM channel compare registers, which it drives.

---
 rtl/pwm_seq_pkg.sv | 17 +
 rtl/pwm_seq_buf.sv | 50 +++++
 rtl/pwm_seq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared types and default widths for the PWM duty sequencer.
// Holds the FSM state enum and default parameter values.
package pwm_seq_pkg;

  localparam int CH_NUM_DEF    = 4;
  localparam int CRX_WIDTH_DEF = 16;
  localparam int DEPTH_DEF     = 8;
  localparam int RPT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_DONE
  } pwm_seq_state_e;

endpackage

// File: rtl/pwm_seq_buf.sv
// pwm_seq_buf: entry register file with append write, length counter,
// clear, and combinational read at rd_idx_i. Ports: wr_en_i/wr_data_i, clr_i, rd_idx_i/rd_data_o, len_o, full_o.
import pwm_seq_pkg::*;

module pwm_seq_buf #(
  parameter int DW    = 64,
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH),
  parameter int LW    = IW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          clr_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [DW-1:0] rd_data_o,
  output logic [LW-1:0] len_o,
  output logic          full_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [LW-1:0] len_q, len_d;

  always_comb begin
    len_d = len_q;
    if (clr_i)
      len_d = '0;
    else if (wr_en_i)
      len_d = len_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      len_q <= '0;
    else
      len_q <= len_d;
  end

  // Contents are not reset; len_q alone says what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clr_i)
      mem_q[len_q[IW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign len_o     = len_q;
  assign full_o    = (len_q == LW'(DEPTH));

endmodule

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: plays buffered compare sets one per PWM period, strobing crr_o.
// Ports: wr_* fill, clr_i/en_i/stop_i control, ov_i period pulse, crr_* out; PWM_SEQ_LOOP_EN adds loop_i.
import pwm_seq_pkg::*;

module pwm_seq_ctrl #(
  parameter int CH_NUM    = CH_NUM_DEF,
  parameter int CRX_WIDTH = CRX_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int RPT_WIDTH = RPT_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          wr_valid_i,
  input  logic [CH_NUM*CRX_WIDTH-1:0]   wr_data_i,
  output logic                          wr_ready_o,
  input  logic                          clr_i,
  input  logic                          en_i,
  input  logic                          stop_i,
  input  logic [RPT_WIDTH-1:0]          rpt_i,
`ifdef PWM_SEQ_LOOP_EN
  input  logic [RPT_WIDTH-1:0]          loop_i,
`endif
  input  logic                          ov_i,
  output logic [CH_NUM*CRX_WIDTH-1:0]   crr_o,
  output logic                          crr_vld_o,
  output logic [$clog2(DEPTH):0]        len_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int DW = CH_NUM * CRX_WIDTH;
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  pwm_seq_state_e state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [RPT_WIDTH-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [RPT_WIDTH-1:0] rpt_val_q, rpt_val_d;
  logic [DW-1:0]        crr_q, crr_d;
  logic                 crr_vld_q, crr_vld_d;
`ifdef PWM_SEQ_LOOP_EN
  logic [RPT_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
`endif

  logic          idle;
  logic          full;
  logic          last;
  logic [LW-1:0] len;
  logic [DW-1:0] rd_data;

  assign idle       = (state_q == ST_IDLE);
  assign wr_ready_o = idle && !full;
  assign last       = !({1'b0, idx_q} < (len - 1'b1));

  pwm_seq_buf #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (wr_valid_i && wr_ready_o && !clr_i),
    .wr_data_i (wr_data_i),
    .clr_i     (clr_i && idle),
    .rd_idx_i  (idx_d),
    .rd_data_o (rd_data),
    .len_o     (len),
    .full_o    (full)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rpt_cnt_d = rpt_cnt_q;
    rpt_val_d = rpt_val_q;
`ifdef PWM_SEQ_LOOP_EN
    loop_cnt_d = loop_cnt_q;
`endif
    if (stop_i && !idle) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (en_i && (len != '0)) begin
            state_d   = ST_LOAD;
            idx_d     = '0;
            rpt_cnt_d = rpt_i;
            rpt_val_d = rpt_i;
`ifdef PWM_SEQ_LOOP_EN
            loop_cnt_d = loop_i;
`endif
          end
        end
        ST_LOAD: state_d = ST_HOLD;
        ST_HOLD: begin
          if (ov_i) begin
            if (rpt_cnt_q != '0) begin
              rpt_cnt_d = rpt_cnt_q - 1'b1;
            end else begin
              rpt_cnt_d = rpt_val_q;
              if (!last) begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_LOAD;
`ifdef PWM_SEQ_LOOP_EN
              end else if (loop_cnt_q != '0) begin
                loop_cnt_d = loop_cnt_q - 1'b1;
                idx_d      = '0;
                state_d    = ST_LOAD;
`endif
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Capture the entry on the way into LOAD so the strobe and
  // its data are both registered during the LOAD cycle.
  always_comb begin
    crr_d     = crr_q;
    crr_vld_d = 1'b0;
    if (state_d == ST_LOAD) begin
      crr_d     = rd_data;
      crr_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rpt_cnt_q <= '0;
      rpt_val_q <= '0;
      crr_q     <= '0;
      crr_vld_q <= 1'b0;
`ifdef PWM_SEQ_LOOP_EN
      loop_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rpt_cnt_q <= rpt_cnt_d;
      rpt_val_q <= rpt_val_d;
      crr_q     <= crr_d;
      crr_vld_q <= crr_vld_d;
`ifdef PWM_SEQ_LOOP_EN
      loop_cnt_q <= loop_cnt_d;
`endif
    end
  end

  assign crr_o     = crr_q;
  assign crr_vld_o = crr_vld_q;
  assign len_o     = len;
  assign busy_o    = !idle;
  assign done_o    = (state_q == ST_DONE);

endmodule
